// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller: FSM state encoding and a state
// classification helper used by both the controller and its datapath.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHIFT      = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_DRAIN_WAIT = 3'd3,
        ST_UNLOAD     = 3'd4
    } scan_state_t;

    // States in which the chain is serially shifted and SO is sampled.
    function automatic logic is_shifting(input scan_state_t st);
        return (st == ST_SHIFT) || (st == ST_UNLOAD);
    endfunction

endpackage

// File: rtl/scan_piso_sipo.sv
// Pattern serializer (parallel-load, MSB-first serial out) and response
// deserializer (serial in from chain tail, parallel out) on a shared strobe.
module scan_piso_sipo #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 shift,
    input  logic                 so,
    output logic                 si,
    output logic [CHAIN_LEN-1:0] cap_data
);

    logic [CHAIN_LEN-1:0] piso_r;
    logic [CHAIN_LEN-1:0] sipo_r;

    // Serializer: zeros fill in behind the pattern, so SI is 0 once it is sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            piso_r <= {CHAIN_LEN{1'b0}};
        end else if (load) begin
            piso_r <= load_data;
        end else if (shift) begin
            piso_r <= {piso_r[CHAIN_LEN-2:0], 1'b0};
        end else begin
            piso_r <= piso_r;
        end
    end

    // Deserializer: first sampled tail bit ends up in the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sipo_r <= {CHAIN_LEN{1'b0}};
        end else if (shift) begin
            sipo_r <= {sipo_r[CHAIN_LEN-2:0], so};
        end else begin
            sipo_r <= sipo_r;
        end
    end

    assign si       = piso_r[CHAIN_LEN-1];
    assign cap_data = sipo_r;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts each pattern in while unloading the previous
// response, pulses capture, and drains the chain after the last pattern.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter  int CHAIN_LEN = 16,
    localparam int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 PAT_VALID,
    output logic                 PAT_READY,
    input  logic [CHAIN_LEN-1:0] PAT_DATA,
    input  logic                 PAT_LAST,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [CHAIN_LEN-1:0] RSP_DATA,
    output logic                 CHAIN_CE,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN - 1);

    scan_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_r;
    logic             has_prev_r;
    logic             rsp_valid_r;
    logic             chain_ce_r;
    logic             se_r;
    logic             load_s;
    logic             shift_s;
    logic             cnt_last_s;

    assign PAT_READY  = (state_r == ST_IDLE) && !rsp_valid_r;
    assign load_s     = PAT_VALID && PAT_READY;
    assign shift_s    = is_shifting(state_r);
    assign cnt_last_s = (cnt_r == CNT_MAX);

    // Sequencer FSM; chain enable and scan enable are set one state ahead.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            last_r      <= 1'b0;
            has_prev_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            chain_ce_r  <= 1'b0;
            se_r        <= 1'b0;
        end else begin
            if (rsp_valid_r && RSP_READY) begin
                rsp_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r    <= ST_SHIFT;
                        cnt_r      <= CNT_ZERO;
                        last_r     <= PAT_LAST;
                        chain_ce_r <= 1'b1;
                        se_r       <= 1'b1;
                    end else begin
                        chain_ce_r <= 1'b0;
                        se_r       <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_last_s) begin
                        state_r <= ST_CAPTURE;
                        cnt_r   <= CNT_ZERO;
                        se_r    <= 1'b0;
                        if (has_prev_r) begin
                            rsp_valid_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_CAPTURE: begin
                    has_prev_r <= 1'b1;
                    chain_ce_r <= 1'b0;
                    se_r       <= 1'b0;
                    state_r    <= last_r ? ST_DRAIN_WAIT : ST_IDLE;
                end
                // The unload overwrites RSP_DATA, so wait for any pending word.
                ST_DRAIN_WAIT: begin
                    if (!rsp_valid_r || RSP_READY) begin
                        state_r    <= ST_UNLOAD;
                        cnt_r      <= CNT_ZERO;
                        chain_ce_r <= 1'b1;
                        se_r       <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (cnt_last_s) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= CNT_ZERO;
                        rsp_valid_r <= 1'b1;
                        has_prev_r  <= 1'b0;
                        chain_ce_r  <= 1'b0;
                        se_r        <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    chain_ce_r <= 1'b0;
                    se_r       <= 1'b0;
                end
            endcase
        end
    end

    scan_piso_sipo #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_piso_sipo (
        .clk      (CLK),
        .rst      (RST),
        .load     (load_s),
        .load_data(PAT_DATA),
        .shift    (shift_s),
        .so       (SO),
        .si       (SI),
        .cap_data (RSP_DATA)
    );

    assign RSP_VALID = rsp_valid_r;
    assign CHAIN_CE  = chain_ce_r;
    assign SE        = se_r;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl at chain lengths 2, 4 and 256, each
// driving a behavioural scan chain model whose capture inputs come from d_w.
module tb_scan_chain_ctrl;

    localparam int LA = 2;
    localparam int LB = 4;
    localparam int LC = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] pat_w;
    logic [255:0] d_w;
    logic         pat_valid_w;
    logic         pat_last_w;
    logic         rsp_ready_w;
    int           sel;
    int           n_run  = 0;
    int           n_fail = 0;

    logic pv_a, pv_b, pv_c, rr_a, rr_b, rr_c;
    logic pr_a, rv_a, ce_a, se_a, si_a;
    logic pr_b, rv_b, ce_b, se_b, si_b;
    logic pr_c, rv_c, ce_c, se_c, si_c;
    logic [LA-1:0] rd_a, chain_a;
    logic [LB-1:0] rd_b, chain_b;
    logic [LC-1:0] rd_c, chain_c;

    logic         pr_m, rv_m, ce_m, se_m, si_m;
    logic [255:0] rd_m, chain_m;
    logic [255:0] got_q[$];

    always #5 clk = ~clk;

    assign pv_a = pat_valid_w && (sel == LA);
    assign pv_b = pat_valid_w && (sel == LB);
    assign pv_c = pat_valid_w && (sel == LC);
    assign rr_a = rsp_ready_w && (sel == LA);
    assign rr_b = rsp_ready_w && (sel == LB);
    assign rr_c = rsp_ready_w && (sel == LC);

    scan_chain_ctrl #(.CHAIN_LEN(LA)) u_dut_a (
        .CLK(clk), .RST(rst), .PAT_VALID(pv_a), .PAT_READY(pr_a),
        .PAT_DATA(pat_w[LA-1:0]), .PAT_LAST(pat_last_w), .RSP_VALID(rv_a),
        .RSP_READY(rr_a), .RSP_DATA(rd_a), .CHAIN_CE(ce_a), .SE(se_a),
        .SI(si_a), .SO(chain_a[LA-1])
    );
    scan_chain_ctrl #(.CHAIN_LEN(LB)) u_dut_b (
        .CLK(clk), .RST(rst), .PAT_VALID(pv_b), .PAT_READY(pr_b),
        .PAT_DATA(pat_w[LB-1:0]), .PAT_LAST(pat_last_w), .RSP_VALID(rv_b),
        .RSP_READY(rr_b), .RSP_DATA(rd_b), .CHAIN_CE(ce_b), .SE(se_b),
        .SI(si_b), .SO(chain_b[LB-1])
    );
    scan_chain_ctrl #(.CHAIN_LEN(LC)) u_dut_c (
        .CLK(clk), .RST(rst), .PAT_VALID(pv_c), .PAT_READY(pr_c),
        .PAT_DATA(pat_w[LC-1:0]), .PAT_LAST(pat_last_w), .RSP_VALID(rv_c),
        .RSP_READY(rr_c), .RSP_DATA(rd_c), .CHAIN_CE(ce_c), .SE(se_c),
        .SI(si_c), .SO(chain_c[LC-1])
    );

    // Scan chain models: gated clock, SE selects SI, otherwise capture d_w.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_a <= {LA{1'b0}};
            chain_b <= {LB{1'b0}};
            chain_c <= {LC{1'b0}};
        end else begin
            if (ce_a) chain_a <= se_a ? {chain_a[LA-2:0], si_a} : d_w[LA-1:0];
            if (ce_b) chain_b <= se_b ? {chain_b[LB-2:0], si_b} : d_w[LB-1:0];
            if (ce_c) chain_c <= se_c ? {chain_c[LC-2:0], si_c} : d_w[LC-1:0];
        end
    end

    // Route the selected instance to the common observation signals.
    always_comb begin
        pr_m = pr_b; rv_m = rv_b; ce_m = ce_b; se_m = se_b; si_m = si_b;
        rd_m = {252'd0, rd_b}; chain_m = {252'd0, chain_b};
        case (sel)
            LA: begin
                pr_m = pr_a; rv_m = rv_a; ce_m = ce_a; se_m = se_a; si_m = si_a;
                rd_m = {254'd0, rd_a}; chain_m = {254'd0, chain_a};
            end
            LC: begin
                pr_m = pr_c; rv_m = rv_c; ce_m = ce_c; se_m = se_c; si_m = si_c;
                rd_m = rd_c; chain_m = chain_c;
            end
            default: begin
                pr_m = pr_b;
            end
        endcase
    end

    // Response sink log: one entry per completed handshake.
    always @(negedge clk) begin
        if (!rst && rv_m && rsp_ready_w) got_q.push_back(rd_m);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pat_valid_w = 1'b0; pat_last_w = 1'b0; rsp_ready_w = 1'b0;
        pat_w = 256'd0; d_w = 256'd0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic send_pat(input logic [255:0] p, input logic last);
        bit done = 1'b0;
        pat_w = p; pat_last_w = last; pat_valid_w = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (pr_m === 1'b1) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        pat_valid_w = 1'b0;
        n_run++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_pat: pat_ready got %b required 1 within 2000 cycles", pr_m);
        end
    endtask

    task automatic wait_rsp(input int bound, output int cycles);
        cycles = 0;
        while (rv_m !== 1'b1 && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        sel = LB;
        do_reset();
        n_run++;
        if ({ce_m, se_m, si_m, rv_m, pr_m} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: {ce,se,si,rv,pr} got %b required 00001", {ce_m, se_m, si_m, rv_m, pr_m});
        end
        n_run++;
        if (rd_m !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h required 0", rd_m[LB-1:0]);
        end
    endtask

    task automatic test_shift_capture();
        logic [255:0] p;
        sel = LB;
        do_reset();
        d_w = 256'h6;
        p = 256'hB;
        send_pat(p, 1'b0);
        for (int k = 0; k < LB; k++) begin
            n_run++;
            if ({ce_m, se_m, si_m} !== {1'b1, 1'b1, p[LB-1-k]}) begin
                n_fail++;
                $display("FAIL shift_cycle%0d: {ce,se,si} got %b required %b", k, {ce_m, se_m, si_m}, {1'b1, 1'b1, p[LB-1-k]});
            end
            tick();
        end
        n_run++;
        if ({ce_m, se_m, si_m, rv_m} !== 4'b1000) begin
            n_fail++;
            $display("FAIL capture_ctrl: {ce,se,si,rv} got %b required 1000", {ce_m, se_m, si_m, rv_m});
        end
        n_run++;
        if (chain_m[LB-1:0] !== 4'b1011) begin
            n_fail++;
            $display("FAIL chain_loaded: got %b required 1011", chain_m[LB-1:0]);
        end
        tick();
        n_run++;
        if ({ce_m, rv_m, pr_m} !== 3'b001) begin
            n_fail++;
            $display("FAIL idle_after_capture: {ce,rv,pr} got %b required 001", {ce_m, rv_m, pr_m});
        end
    endtask

    task automatic test_drain();
        int cyc;
        sel = LB;
        do_reset();
        d_w = 256'h6;
        send_pat(256'hB, 1'b0);
        send_pat(256'h1, 1'b1);
        wait_rsp(10, cyc);
        n_run++;
        if (rv_m !== 1'b1 || cyc != LB) begin
            n_fail++;
            $display("FAIL first_rsp_latency: rv %b after %0d cycles, required 1 after %0d", rv_m, cyc, LB);
        end
        n_run++;
        if (rd_m[LB-1:0] !== 4'b0110) begin
            n_fail++;
            $display("FAIL first_rsp_data: got %b required 0110", rd_m[LB-1:0]);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            n_run++;
            if ({ce_m, rv_m, chain_m[LB-1:0]} !== {1'b0, 1'b1, 4'b0110}) begin
                n_fail++;
                $display("FAIL drain_wait_hold%0d: {ce,rv,chain} got %b required 010110", i, {ce_m, rv_m, chain_m[LB-1:0]});
            end
            tick();
        end
        rsp_ready_w = 1'b1;
        tick();
        rsp_ready_w = 1'b0;
        n_run++;
        if ({ce_m, se_m, si_m, rv_m} !== 4'b1100) begin
            n_fail++;
            $display("FAIL unload_start: {ce,se,si,rv} got %b required 1100", {ce_m, se_m, si_m, rv_m});
        end
        wait_rsp(10, cyc);
        n_run++;
        if (rv_m !== 1'b1 || cyc != LB) begin
            n_fail++;
            $display("FAIL drain_rsp_latency: rv %b after %0d cycles, required 1 after %0d", rv_m, cyc, LB);
        end
        n_run++;
        if ({rd_m[LB-1:0], chain_m[LB-1:0], pr_m} !== {4'b0110, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_rsp: {rsp,chain,pr} got %b required 011000000", {rd_m[LB-1:0], chain_m[LB-1:0], pr_m});
        end
        rsp_ready_w = 1'b1;
        tick();
        rsp_ready_w = 1'b0;
        n_run++;
        if ({rv_m, pr_m, ce_m} !== 3'b010) begin
            n_fail++;
            $display("FAIL after_drain: {rv,pr,ce} got %b required 010", {rv_m, pr_m, ce_m});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        sel = LB;
        do_reset();
        d_w = 256'h9;
        send_pat(256'h3, 1'b0);
        send_pat(256'h5, 1'b0);
        d_w = 256'hC;
        pat_w = 256'hE; pat_last_w = 1'b0; pat_valid_w = 1'b1;
        wait_rsp(10, cyc);
        n_run++;
        if (rv_m !== 1'b1 || rd_m[LB-1:0] !== 4'h9) begin
            n_fail++;
            $display("FAIL b2b_rsp1: rv %b data %h, required rv 1 data 9", rv_m, rd_m[LB-1:0]);
        end
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (pr_m !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ready_blocked%0d: pat_ready got %b required 0", i, pr_m);
            end
            tick();
        end
        rsp_ready_w = 1'b1;
        tick();
        rsp_ready_w = 1'b0;
        n_run++;
        if ({rv_m, pr_m, ce_m} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_after_handshake: {rv,pr,ce} got %b required 010", {rv_m, pr_m, ce_m});
        end
        tick();
        pat_valid_w = 1'b0;
        n_run++;
        if ({ce_m, se_m, si_m, pr_m} !== 4'b1110) begin
            n_fail++;
            $display("FAIL b2b_accept: {ce,se,si,pr} got %b required 1110", {ce_m, se_m, si_m, pr_m});
        end
        wait_rsp(10, cyc);
        n_run++;
        if (rv_m !== 1'b1 || cyc != LB || rd_m[LB-1:0] !== 4'hC) begin
            n_fail++;
            $display("FAIL b2b_rsp2: rv %b cycles %0d data %h, required 1 %0d c", rv_m, cyc, rd_m[LB-1:0], LB);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        sel = LB;
        do_reset();
        rsp_ready_w = 1'b1;
        d_w = 256'h5;
        send_pat(256'hA, 1'b0);
        send_pat(256'h7, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++;
        if ({ce_m, se_m, si_m, rv_m, pr_m} !== 5'b00001) begin
            n_fail++;
            $display("FAIL mid_reset: {ce,se,si,rv,pr} got %b required 00001", {ce_m, se_m, si_m, rv_m, pr_m});
        end
        send_pat(256'h3, 1'b0);
        for (int i = 0; i < LB + 4; i++) begin
            if (rv_m === 1'b1) seen = 1'b1;
            tick();
        end
        n_run++;
        if (seen || pr_m !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_no_rsp: rsp seen %b pr %b, required seen 0 pr 1", seen, pr_m);
        end
    endtask

    task automatic test_sweep(input int len, input int n);
        logic [255:0] mask;
        logic [255:0] p;
        logic [255:0] d;
        logic [255:0] exp_q[$];
        int           guard = 0;
        sel = len;
        do_reset();
        rsp_ready_w = 1'b1;
        got_q.delete();
        mask = (256'd1 << len) - 256'd1;
        for (int i = 0; i < n; i++) begin
            p = rand256() & mask;
            send_pat(p, (i == n - 1));
            d = rand256() & mask;
            d_w = d;
            exp_q.push_back(d);
        end
        while (got_q.size() < n && guard < 4 * (len + 4)) begin
            tick();
            guard++;
        end
        n_run++;
        if (got_q.size() != n) begin
            n_fail++;
            $display("FAIL sweep%0d_count: got %0d responses required %0d", len, got_q.size(), n);
        end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            n_run++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sweep%0d_rsp%0d: got %h required %h", len, i, got_q[i], exp_q[i]);
            end
        end
        n_run++;
        if (chain_m !== 256'd0 || pr_m !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep%0d_drained: chain %h pr %b, required 0 and 1", len, chain_m, pr_m);
        end
    endtask

    initial begin
        sel = LB; rst = 1'b1; pat_w = 256'd0; d_w = 256'd0;
        pat_valid_w = 1'b0; pat_last_w = 1'b0; rsp_ready_w = 1'b0;
        test_reset();
        test_shift_capture();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_sweep(LA, 6);
        test_sweep(LB, 5);
        test_sweep(LC, 4);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
